fft_spi_master: RTL and testbench

FPGA-side SPI controller that drives the MCU-facing FFT frame link from the opposite end: it generates `sck`/`cs`, shifts out a 1024-bit frame on `mosi`, and captures 1024 bits from `miso` full-duplex. The transmit frame is assembled from 32 words of 32 bits via a valid/ready input stream. The received frame is returned as 32 words on a valid/ready output stream. It is the bench/bring-up master for `fft_spi` and the controller for external SPI frame peripherals.

---
 rtl/fft_spi_master.sv | 194 +++++++++++++++++++
 tb/tb_fft_spi_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_spi_master.sv
// SPI frame master: assembles a FRAME_BITS transmit frame from a word stream, shifts it out full-duplex,
// and returns the captured frame as words. Define SPI_LOOPBACK_EN to add the loopback input.
module fft_spi_master #(
    parameter int FRAME_BITS = 1024,
    parameter int WORD_BITS  = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 sck,
    output logic                 cs,
    output logic                 mosi,
`ifdef SPI_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic                 miso
);
    localparam int NWORDS = FRAME_BITS / WORD_BITS;
    localparam int WCNT_W = $clog2(NWORDS) + 1;
    localparam int BCNT_W = $clog2(FRAME_BITS) + 1;
    localparam int DIV_W  = $clog2(CLK_DIV) + 1;

    localparam logic [2:0] S_FILL  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]            r_state;
    logic [WCNT_W-1:0]     r_wcnt;
    logic [BCNT_W-1:0]     r_bcnt;
    logic [DIV_W-1:0]      r_div;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [WORD_BITS-1:0]  r_out_data;
    logic                  r_busy;
    logic                  r_sck;
    logic                  r_cs;
    logic                  r_mosi;
    logic [FRAME_BITS-1:0] r_tx;
    logic [FRAME_BITS-1:0] r_rx;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_div_tc;
    logic                  w_bits_done;
    logic                  w_rise;
    logic                  w_fall_shift;
    logic                  w_drain_pop;
    logic                  w_rx_bit;
    logic [FRAME_BITS-1:0] w_tx_next;

    assign w_in_fire    = r_in_ready && in_valid;
    assign w_out_fire   = r_out_valid && out_ready;
    assign w_div_tc     = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_bits_done  = (r_bcnt == BCNT_W'(FRAME_BITS));
    assign w_tx_next    = (r_tx << WORD_BITS) | FRAME_BITS'(in_data);
    // The first rise closes the setup interval; later rises come from SHIFT while bits remain.
    assign w_rise       = w_div_tc && ((r_state == S_SETUP) ||
                          (r_state == S_SHIFT && !r_sck && !w_bits_done));
    assign w_fall_shift = (r_state == S_SHIFT) && w_div_tc && r_sck && !w_bits_done;
    assign w_drain_pop  = (r_state == S_DRAIN) && w_out_fire;

`ifdef SPI_LOOPBACK_EN
    assign w_rx_bit = loopback ? r_mosi : miso;
`else
    assign w_rx_bit = miso;
`endif

    // Frame shift registers carry no reset: every frame fully overwrites them.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_tx <= w_tx_next;
        end else if (w_fall_shift) begin
            r_tx <= r_tx << 1;
        end
        if (w_rise) begin
            r_rx <= {r_rx[FRAME_BITS-2:0], w_rx_bit};
        end else if (w_drain_pop) begin
            r_rx <= r_rx << WORD_BITS;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_FILL;
            r_wcnt      <= '0;
            r_bcnt      <= '0;
            r_div       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_sck       <= 1'b0;
            r_cs        <= 1'b0;
            r_mosi      <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_div <= '0;
                    if (w_in_fire && r_wcnt == WCNT_W'(NWORDS - 1)) begin
                        r_in_ready <= 1'b0;
                        r_cs       <= 1'b1;
                        r_busy     <= 1'b1;
                        r_mosi     <= w_tx_next[FRAME_BITS-1];
                        r_wcnt     <= '0;
                        r_bcnt     <= '0;
                        r_state    <= S_SETUP;
                    end else begin
                        r_in_ready <= 1'b1;
                        if (w_in_fire) begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (w_div_tc) begin
                        r_div   <= '0;
                        r_sck   <= 1'b1;
                        r_bcnt  <= r_bcnt + 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_SHIFT: begin
                    // After the last rise, one more low half-period completes the final sck period.
                    if (w_div_tc) begin
                        r_div <= '0;
                        if (r_sck) begin
                            r_sck <= 1'b0;
                            if (!w_bits_done) begin
                                r_mosi <= r_tx[FRAME_BITS-2];
                            end
                        end else if (w_bits_done) begin
                            r_bcnt  <= '0;
                            r_state <= S_HOLD;
                        end else begin
                            r_sck  <= 1'b1;
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_div_tc) begin
                        r_div       <= '0;
                        r_cs        <= 1'b0;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_rx[FRAME_BITS-1 -: WORD_BITS];
                        r_wcnt      <= '0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        if (r_wcnt == WCNT_W'(NWORDS - 1)) begin
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_wcnt      <= '0;
                            r_state     <= S_FILL;
                        end else begin
                            r_out_data <= r_rx[FRAME_BITS-WORD_BITS-1 -: WORD_BITS];
                            r_wcnt     <= r_wcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign sck       = r_sck;
    assign cs        = r_cs;
    assign mosi      = r_mosi;

endmodule

// File: tb/tb_fft_spi_master.sv
// Bench for fft_spi_master: two instances (CLK_DIV=4 and CLK_DIV=1) driven one at a time,
// with a frame-level slave model and a word scoreboard on the output stream.
module tb_fft_spi_master;
    localparam int FB = 1024;
    localparam int WB = 32;
    localparam int NW = FB / WB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n      = 1'b0;
    logic          act          = 1'b0;
    logic [WB-1:0] tb_in_data   = '0;
    logic          tb_in_valid  = 1'b0;
    logic          tb_out_ready = 1'b1;
    logic          tb_miso;
`ifdef SPI_LOOPBACK_EN
    logic          tb_loopback  = 1'b0;
`endif

    logic in_ready0, out_valid0, busy0, sck0, cs0, mosi0;
    logic in_ready1, out_valid1, busy1, sck1, cs1, mosi1;
    logic [WB-1:0] out_data0, out_data1;

    fft_spi_master #(.FRAME_BITS(FB), .WORD_BITS(WB), .CLK_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(tb_in_data), .in_valid(tb_in_valid && !act), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(tb_out_ready),
        .busy(busy0), .sck(sck0), .cs(cs0), .mosi(mosi0),
`ifdef SPI_LOOPBACK_EN
        .loopback(tb_loopback),
`endif
        .miso(tb_miso)
    );

    fft_spi_master #(.FRAME_BITS(FB), .WORD_BITS(WB), .CLK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_data(tb_in_data), .in_valid(tb_in_valid && act), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(tb_out_ready),
        .busy(busy1), .sck(sck1), .cs(cs1), .mosi(mosi1),
`ifdef SPI_LOOPBACK_EN
        .loopback(tb_loopback),
`endif
        .miso(tb_miso)
    );

    logic          w_in_ready, w_out_valid, w_busy, w_sck, w_cs, w_mosi;
    logic [WB-1:0] w_out_data;
    assign w_in_ready  = act ? in_ready1  : in_ready0;
    assign w_out_valid = act ? out_valid1 : out_valid0;
    assign w_out_data  = act ? out_data1  : out_data0;
    assign w_busy      = act ? busy1      : busy0;
    assign w_sck       = act ? sck1       : sck0;
    assign w_cs        = act ? cs1        : cs0;
    assign w_mosi      = act ? mosi1      : mosi0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Slave model: the frame it returns, indexed by how many sck rises it has seen.
    logic [FB-1:0] slv_frame = '0;
    logic [FB-1:0] mosi_cap  = '0;
    logic [FB-1:0] exp_tx    = '0;
    int            rise_cnt  = 0;
    logic [WB-1:0] tx_words [NW];

    always @(posedge w_cs) rise_cnt = 0;
    always @(posedge w_sck) begin
        if (rise_cnt < FB) mosi_cap[FB-1-rise_cnt] = w_mosi;
        rise_cnt++;
    end
    assign tb_miso = (rise_cnt < FB) ? slv_frame[FB-1-rise_cnt] : 1'b0;

    logic [WB-1:0] exp_q [$];
    bit rnd_ready = 0;
    bit bp_mode   = 0;
    int bp_cnt    = 0;
    int mutex_err = 0;

    always @(posedge clk) begin
        if (!bp_mode) bp_cnt <= 0;
        if (bp_mode && (NW - exp_q.size()) == 5 && bp_cnt < 10) begin
            tb_out_ready <= 1'b0;
            bp_cnt       <= bp_cnt + 1;
        end else if (rnd_ready) begin
            tb_out_ready <= ($urandom_range(0, 3) != 0);
        end else begin
            tb_out_ready <= 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on every accepted output word.
    always @(negedge clk) begin
        if (reset_n) begin
            if (w_in_ready && w_out_valid) mutex_err++;
            if (bp_mode && !tb_out_ready && exp_q.size() > 0) begin
                check("bp_valid_held", w_out_valid, 1);
                check("bp_data_held", w_out_data, exp_q[0]);
            end
            if (w_out_valid && tb_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", w_out_valid, 0);
                end else begin
                    logic [WB-1:0] e;
                    int idx;
                    idx = NW - exp_q.size();
                    e = exp_q.pop_front();
                    check($sformatf("out_word%0d", idx), w_out_data, e);
                end
            end
        end
    end

    task automatic send_words(input bit gaps);
        for (int i = 0; i < NW; i++) begin
            int guard;
            if (gaps && $urandom_range(0, 3) == 0) begin
                tb_in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            tb_in_valid = 1'b1;
            tb_in_data  = tx_words[i];
            guard = 0;
            while (!w_in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (!w_in_ready) begin
                check("in_ready_timeout", w_in_ready, 1);
                tb_in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tb_in_valid = 1'b0;
    endtask

    task automatic load_frame(input bit lb, input bit gaps);
        for (int i = 0; i < NW; i++) begin
            exp_tx[FB-1-WB*i -: WB] = tx_words[i];
            exp_q.push_back(lb ? tx_words[i] : slv_frame[FB-1-WB*i -: WB]);
        end
        send_words(gaps);
    endtask

    task automatic finish_frame(input int div, input bit junk);
        int guard;
        int width;
        guard = 0;
        while (!w_cs && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("cs_rise", w_cs, 1);
        width = 0;
        while (w_cs && width < 20000) begin
            if (junk) begin
                tb_in_valid = 1'b1;
                tb_in_data  = $urandom;
            end
            width++;
            @(negedge clk);
        end
        tb_in_valid = 1'b0;
        check("cs_high_width", width, div * (2 * FB + 2));
        check("busy_low_after_cs", w_busy, 0);
        check("first_out_valid_at_cs_fall", w_out_valid, 1);
        check("sck_rise_count", rise_cnt, FB);
        check("mosi_stream", mosi_cap === exp_tx, 1);
        guard = 0;
        while (exp_q.size() != 0 && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        check("words_remaining", exp_q.size(), 0);
        @(negedge clk);
        check("out_valid_after_drain", w_out_valid, 0);
        check("in_ready_after_drain", w_in_ready, 1);
    endtask

    task automatic rand_frame(input int div);
        for (int i = 0; i < NW; i++) begin
            tx_words[i] = $urandom;
            slv_frame[FB-1-WB*i -: WB] = $urandom;
        end
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check("rst_in_ready", w_in_ready, 0);
        check("rst_out_valid", w_out_valid, 0);
        check("rst_out_data", w_out_data, 0);
        check("rst_busy", w_busy, 0);
        check("rst_sck", w_sck, 0);
        check("rst_cs", w_cs, 0);
        check("rst_mosi", w_mosi, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_release", w_in_ready, 1);

        // Full frame: counting words, slave returns 0xA5A5A5A5
        for (int i = 0; i < NW; i++) begin
            tx_words[i] = 32'(i);
            slv_frame[FB-1-WB*i -: WB] = 32'hA5A5A5A5;
        end
        load_frame(0, 0);
        finish_frame(4, 0);

        // Random data, random output stalls, input gaps, junk input while busy
        rand_frame(4);
        rnd_ready = 1;
        load_frame(0, 1);
        finish_frame(4, 1);
        rnd_ready = 0;

        // Back-pressure on word 5
        rand_frame(4);
        bp_mode = 1;
        load_frame(0, 0);
        finish_frame(4, 0);
        check("bp_stall_cycles", bp_cnt, 10);
        bp_mode = 0;

        // Reset after sck rise 500
        rand_frame(4);
        load_frame(0, 0);
        begin
            int guard;
            guard = 0;
            while (rise_cnt < 500 && guard < 10000) begin
                @(negedge clk);
                guard++;
            end
            check("reached_rise_500", rise_cnt >= 500, 1);
        end
        #2 reset_n = 1'b0;
        #1;
        check("midrst_cs", w_cs, 0);
        check("midrst_sck", w_sck, 0);
        check("midrst_mosi", w_mosi, 0);
        check("midrst_busy", w_busy, 0);
        check("midrst_out_valid", w_out_valid, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NW; i++) begin
            tx_words[i] = 32'h12345678;
            slv_frame[FB-1-WB*i -: WB] = $urandom;
        end
        load_frame(0, 0);
        finish_frame(4, 0);

`ifdef SPI_LOOPBACK_EN
        // Loopback: RX follows mosi, slave data is random noise
        tb_loopback = 1'b1;
        for (int i = 0; i < NW; i++) begin
            tx_words[i] = 32'hDEADBEEF + 32'(i);
            slv_frame[FB-1-WB*i -: WB] = $urandom;
        end
        load_frame(1, 0);
        finish_frame(4, 0);
        tb_loopback = 1'b0;
`endif

        // Minimum divider instance
        act = 1'b1;
        @(negedge clk);
        check("div1_in_ready_idle", w_in_ready, 1);
        for (int i = 0; i < NW; i++) begin
            tx_words[i] = 32'(i);
            slv_frame[FB-1-WB*i -: WB] = 32'hA5A5A5A5;
        end
        load_frame(0, 0);
        finish_frame(1, 0);
        rand_frame(1);
        rnd_ready = 1;
        load_frame(0, 1);
        finish_frame(1, 0);
        rnd_ready = 0;

        check("in_ready_out_valid_exclusive", mutex_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
